alu_seq: RTL and testbench

Sequential, parametrised successor to the processor's combinational ALU. Operands are latched on a start handshake; results are returned in registered outputs. PASS/ADD/SUB/SHL complete in one cycle. MUL runs as a shift-add loop and DIV as a restoring loop, so no wide combinational multiplier or divider sits in the datapath. It sits in the execute stage and stalls the pipeline via `Ready`/`Done`.

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_divstep.sv | 26 ++
 rtl/alu_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential ALU.
//   ALU_OP_W     - opcode width
//   alu_op_e     - operation encoding (OP_PASS .. OP_SHL, plus the two no-op codes)
//   alu_state_e  - control FSM states; ST_DIV_FRAC exists only when
//                  ALU_SEQ_FRAC_EN is defined
package alu_seq_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_NONE = 3'b000,
    OP_PASS = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100,
    OP_DIV  = 3'b101,
    OP_SHL  = 3'b110,
    OP_RSVD = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL      = 2'd1,
`ifdef ALU_SEQ_FRAC_EN
    ST_DIV_INT  = 2'd2,
    ST_DIV_FRAC = 2'd3
`else
    ST_DIV_INT  = 2'd2
`endif
  } alu_state_e;

endpackage

// File: rtl/alu_seq_divstep.sv
// alu_seq_divstep: one combinational restoring-division step.
//   rem_i  - partial remainder (always < div_i)
//   div_i  - divisor (non-zero)
//   bit_i  - next dividend bit shifted in below the remainder
//   rem_o  - next partial remainder
//   q_o    - quotient bit produced by this step
module alu_seq_divstep #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] trial;

  // rem_i < div_i, so trial < 2*div_i and the restored value fits in WIDTH bits.
  always_comb begin
    trial = {rem_i, bit_i};
    q_o   = (trial >= {1'b0, div_i});
    rem_o = q_o ? WIDTH'(trial - {1'b0, div_i}) : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with start/ready/done handshake.
//   Clk, Reset       - clock, asynchronous active-high reset
//   Start, OP        - request and opcode, sampled while Ready=1
//   InputA, InputB   - operands, latched with Start
//   Ready            - idle, can accept Start
//   Done             - one-cycle pulse, results valid
//   Out1, Out2       - primary / secondary result (held until next result)
//   Zero, DivZero    - Out1==0, divide-by-zero flag (registered with results)
// PASS/ADD/SUB/SHL finish at the sampling edge; MUL is a WIDTH-step shift-add
// loop, DIV a WIDTH-step restoring loop. Define ALU_SEQ_FRAC_EN to add a
// FRAC_BITS-step fractional quotient phase that replaces the remainder in Out2.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic [ALU_OP_W-1:0] OP,
  input  logic [WIDTH-1:0]    InputA,
  input  logic [WIDTH-1:0]    InputB,
  output logic                Ready,
  output logic                Done,
  output logic [WIDTH-1:0]    Out1,
  output logic [WIDTH-1:0]    Out2,
  output logic                Zero,
  output logic                DivZero
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  INT_LAST = CW'(WIDTH - 1);
`ifdef ALU_SEQ_FRAC_EN
  localparam logic [CW-1:0]  FRAC_LAST = CW'(FRAC_BITS - 1);
`endif

  alu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // a: multiplicand / divisor; hi: product high half / partial remainder;
  // lo: multiplier being consumed / dividend shifting out, quotient shifting in.
  logic [WIDTH-1:0] a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] out1_q, out1_d, out2_q, out2_d;
  logic             zero_q, zero_d, divz_q, divz_d, done_q, done_d;
`ifdef ALU_SEQ_FRAC_EN
  logic [WIDTH-1:0] frac_q, frac_d;
`endif

  logic [WIDTH:0]     add_r, sub_r, mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   res1, res2, ds_rem;
  logic               res_dz, wr, ds_q, ds_bit;

`ifdef ALU_SEQ_FRAC_EN
  assign ds_bit = (state_q == ST_DIV_INT) ? lo_q[WIDTH-1] : 1'b0;
`else
  assign ds_bit = lo_q[WIDTH-1];
`endif

  alu_seq_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i (hi_q),
    .div_i (a_q),
    .bit_i (ds_bit),
    .rem_o (ds_rem),
    .q_o   (ds_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    zero_d  = zero_q;
    divz_d  = divz_q;
    done_d  = 1'b0;
`ifdef ALU_SEQ_FRAC_EN
    frac_d  = frac_q;
`endif
    res1    = '0;
    res2    = '0;
    res_dz  = 1'b0;
    wr      = 1'b0;

    add_r    = {1'b0, InputA} + {1'b0, InputB};
    sub_r    = {1'b0, InputA} - {1'b0, InputB};
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    prod_nxt = {mul_sum, lo_q[WIDTH-1:1]};

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          case (alu_op_e'(OP))
            OP_PASS: begin wr = 1'b1; res1 = InputB; end
            OP_ADD:  begin
              wr = 1'b1; res1 = add_r[WIDTH-1:0];
              res2 = {{(WIDTH-1){1'b0}}, add_r[WIDTH]};
            end
            OP_SUB:  begin
              wr = 1'b1; res1 = sub_r[WIDTH-1:0];
              res2 = {{(WIDTH-1){1'b0}}, sub_r[WIDTH]};
            end
            OP_SHL:  begin
              wr = 1'b1;
              res1 = (InputB >= WIDTH'(WIDTH)) ? '0 : (InputA << InputB);
            end
            OP_MUL:  begin
              a_d = InputA; hi_d = '0; lo_d = InputB;
              cnt_d = '0; state_d = ST_MUL;
            end
            OP_DIV:  begin
              if (InputB == '0) begin
                wr = 1'b1; res1 = '1; res2 = InputA; res_dz = 1'b1;
              end else begin
                a_d = InputB; hi_d = '0; lo_d = InputA;
                cnt_d = '0; state_d = ST_DIV_INT;
              end
            end
            default: wr = 1'b1;  // unused codes return zeros
          endcase
        end
      end
      ST_MUL: begin
        hi_d  = prod_nxt[2*WIDTH-1:WIDTH];
        lo_d  = prod_nxt[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INT_LAST) begin
          wr = 1'b1; res1 = lo_d; res2 = hi_d; state_d = ST_IDLE;
        end
      end
      ST_DIV_INT: begin
        hi_d  = ds_rem;
        lo_d  = {lo_q[WIDTH-2:0], ds_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INT_LAST) begin
`ifdef ALU_SEQ_FRAC_EN
          cnt_d = '0; frac_d = '0; state_d = ST_DIV_FRAC;
`else
          wr = 1'b1; res1 = lo_d; res2 = ds_rem; state_d = ST_IDLE;
`endif
        end
      end
`ifdef ALU_SEQ_FRAC_EN
      ST_DIV_FRAC: begin
        // Keep dividing the remainder with zeros shifted in; quotient stays in lo.
        hi_d   = ds_rem;
        frac_d = {frac_q[WIDTH-2:0], ds_q};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == FRAC_LAST) begin
          wr = 1'b1; res1 = lo_q; res2 = frac_d; state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (wr) begin
      out1_d = res1;
      out2_d = res2;
      zero_d = (res1 == '0);
      divz_d = res_dz;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      zero_q  <= 1'b1;
      divz_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_SEQ_FRAC_EN
      frac_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      zero_q  <= zero_d;
      divz_q  <= divz_d;
      done_q  <= done_d;
`ifdef ALU_SEQ_FRAC_EN
      frac_q  <= frac_d;
`endif
    end
  end

  assign Ready   = (state_q == ST_IDLE);
  assign Done    = done_q;
  assign Out1    = out1_q;
  assign Out2    = out2_q;
  assign Zero    = zero_q;
  assign DivZero = divz_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed scoreboard bench for alu_seq (WIDTH=16, FRAC_BITS=8).
// Stimulus pushes expected results; the monitor pops and compares on Done.
module tb_alu_seq;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  OP = '0;
  logic [15:0] InputA = '0, InputB = '0;
  logic        Ready, Done, Zero, DivZero;
  logic [15:0] Out1, Out2;

  alu_seq #(.WIDTH(16), .FRAC_BITS(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .OP(OP),
    .InputA(InputA), .InputB(InputB), .Ready(Ready), .Done(Done),
    .Out1(Out1), .Out2(Out2), .Zero(Zero), .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

`ifdef ALU_SEQ_FRAC_EN
  localparam int          DIV_LAT  = 24;
  localparam logic [15:0] R100_7   = 16'h0049;
  localparam logic [15:0] R200_9   = 16'h0038;
`else
  localparam int          DIV_LAT  = 16;
  localparam logic [15:0] R100_7   = 16'd2;
  localparam logic [15:0] R200_9   = 16'd2;
`endif

  typedef struct {
    string       name;
    logic [15:0] o1, o2;
    logic        z, dz;
    int          lat;
    int          start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: compare each Done against the oldest expected entry.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (!Reset && Done) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, ".out1"}, 32'(Out1), 32'(e.o1));
        chk({e.name, ".out2"}, 32'(Out2), 32'(e.o2));
        chk({e.name, ".zero"}, 32'(Zero), 32'(e.z));
        chk({e.name, ".divzero"}, 32'(DivZero), 32'(e.dz));
        chk({e.name, ".latency"}, 32'(cyc - e.start), 32'(e.lat));
      end
    end
  end

  // Drive one request for exactly one sampling edge.
  task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input string nm, input logic [15:0] o1, input logic [15:0] o2,
                       input logic z, input logic dz, input int lat, input bit push);
    exp_t e;
    OP = op; InputA = a; InputB = b; Start = 1'b1;
    if (push) begin
      e.name = nm; e.o1 = o1; e.o2 = o2; e.z = z; e.dz = dz;
      e.lat = lat; e.start = cyc + 1;
      sb.push_back(e);
    end
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input string nm, input logic [15:0] o1, input logic [15:0] o2,
                       input logic z, input logic dz, input int lat);
    @(negedge Clk);
    drive(op, a, b, nm, o1, o2, z, dz, lat, 1'b1);
  endtask

  // Returns inside the Done cycle (before its negedge).
  task automatic wait_done(input string nm, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (Done) return;
      @(posedge Clk);
      #2;
    end
    checks++; failures++;
    $display("FAIL %s_timeout actual=no_done expected=done_within_%0d", nm, bound);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst.out1", 32'(Out1), 32'h0);
    chk("rst.out2", 32'(Out2), 32'h0);
    chk("rst.zero", 32'(Zero), 32'h1);
    chk("rst.divzero", 32'(DivZero), 32'h0);
    chk("rst.done", 32'(Done), 32'h0);
    chk("rst.ready", 32'(Ready), 32'h1);

    issue(3'b010, 16'hFFFF, 16'h0001, "add_wrap", 16'h0000, 16'h0001, 1'b1, 1'b0, 0);
    wait_done("add_wrap", 5);
    issue(3'b011, 16'h0005, 16'h0007, "sub_borrow", 16'hFFFE, 16'h0001, 1'b0, 1'b0, 0);
    wait_done("sub_borrow", 5);

    issue(3'b100, 16'h1234, 16'h0100, "mul", 16'h3400, 16'h0012, 1'b0, 1'b0, 16);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (Ready) break;
      n++;
      @(posedge Clk);
      #2;
    end
    chk("mul.ready_low_cycles", 32'(n), 32'd16);

    issue(3'b101, 16'd100, 16'd7, "div100_7", 16'd14, R100_7, 1'b0, 1'b0, DIV_LAT);
    wait_done("div100_7", 40);

    issue(3'b101, 16'h0055, 16'h0000, "div_zero", 16'hFFFF, 16'h0055, 1'b0, 1'b1, 0);
    wait_done("div_zero", 5);
    issue(3'b001, 16'h0000, 16'h0001, "pass", 16'h0001, 16'h0000, 1'b0, 1'b0, 0);
    wait_done("pass", 5);

    issue(3'b111, 16'h1111, 16'h2222, "op_rsvd", 16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    wait_done("op_rsvd", 5);

    // A Start mid-DIV is dropped; a Start in the Done cycle is taken.
    issue(3'b101, 16'd200, 16'd9, "div200_9", 16'd22, R200_9, 1'b0, 1'b0, DIV_LAT);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    drive(3'b100, 16'd3, 16'd5, "ignored", 16'd0, 16'd0, 1'b0, 1'b0, 0, 1'b0);
    wait_done("div200_9", 40);
    chk("b2b.ready", 32'(Ready), 32'h1);
    issue(3'b100, 16'd3, 16'd5, "mul_b2b", 16'd15, 16'd0, 1'b0, 1'b0, 16);
    wait_done("mul_b2b", 40);

    // Reset in the middle of a DIV aborts it.
    issue(3'b101, 16'd1000, 16'd3, "div_abort", 16'd333, 16'd0, 1'b0, 1'b0, DIV_LAT);
    repeat (4) @(posedge Clk);
    #2 Reset = 1'b1;
    sb.delete();
    #1;
    chk("abort.done", 32'(Done), 32'h0);
    chk("abort.out1", 32'(Out1), 32'h0);
    chk("abort.zero", 32'(Zero), 32'h1);
    chk("abort.ready", 32'(Ready), 32'h1);
    @(negedge Clk);
    Reset = 1'b0;
    drive(3'b110, 16'h0003, 16'd4, "shl4", 16'h0030, 16'h0000, 1'b0, 1'b0, 0, 1'b1);
    wait_done("shl4", 5);
    issue(3'b110, 16'h0003, 16'd16, "shl16", 16'h0000, 16'h0000, 1'b1, 1'b0, 0);
    wait_done("shl16", 5);
    issue(3'b110, 16'h8001, 16'd15, "shl15", 16'h8000, 16'h0000, 1'b0, 1'b0, 0);
    wait_done("shl15", 5);

    repeat (30) @(posedge Clk);
    #2;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
